// File: rtl/acc_adder_stage.sv
// Registered accumulation stage: a burst of LEN operands is summed through a
// full-adder carry chain, and the sum plus carry-out count come out on a valid/ready port.

module acc_adder_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module acc_adder_stage #(
   parameter int N     = 4,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_sum,
   output logic [CNT_W-1:0] out_carry_cnt,
   output logic             out_ovf,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

   state_t           state, state_nxt;
   logic [N-1:0]     acc, acc_nxt;
   logic [CNT_W-1:0] rem, rem_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   // Ripple carry chain, carry-in tied low; carry[N] is the adder carry-out.
   logic [N:0]   carry;
   logic [N-1:0] add_sum;

   assign carry[0] = 1'b0;

   genvar i;
   generate
      for (i = 0; i < N; i++) begin : g_fa
         acc_adder_fa u_fa (
            .a  (acc[i]),
            .b  (in_data[i]),
            .ci (carry[i]),
            .s  (add_sum[i]),
            .co (carry[i+1])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         acc   <= '0;
         rem   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         rem   <= rem_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      rem_nxt   = rem;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (start) begin
               acc_nxt = '0;
               cnt_nxt = '0;
               if (len != '0) begin
                  rem_nxt   = len;
                  state_nxt = ACC;
               end else begin
                  state_nxt = HOLD;
               end
            end
         end
         ACC: begin
            // in_ready is 1 throughout ACC, so in_valid alone is the handshake
            if (in_valid) begin
               acc_nxt = add_sum;
               rem_nxt = rem - CNT_W'(1);
               if (carry[N] && (cnt != '1))
                  cnt_nxt = cnt + CNT_W'(1);
               if (rem == CNT_W'(1))
                  state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign in_ready      = (state == ACC);
   assign out_valid     = (state == HOLD);
   assign busy          = (state != IDLE);
   assign out_sum       = acc;
   assign out_carry_cnt = cnt;
   assign out_ovf       = |cnt;

endmodule

// File: tb/tb_acc_adder_stage.sv
// Directed bench for acc_adder_stage: hand-computed bursts, gaps, HOLD backpressure, mid-burst reset.

module tb_acc_adder_stage;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] len;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_sum;
   logic [3:0] out_carry_cnt;
   logic       out_ovf;
   logic       busy;

   int checks = 0;
   int errors = 0;

   acc_adder_stage #(.N(4), .CNT_W(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .len           (len),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_sum       (out_sum),
      .out_carry_cnt (out_carry_cnt),
      .out_ovf       (out_ovf),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one operand after 'gap' idle cycles; in_ready must stay high through the gap.
   task automatic feed(input logic [3:0] d, input int gap, input string tag);
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         step();
         check({tag, "_gap_ready"}, in_ready, 1);
      end
      in_valid = 1'b1;
      in_data  = d;
      step();
      in_valid = 1'b0;
   endtask

   task automatic start_burst(input logic [3:0] l);
      start = 1'b1;
      len   = l;
      step();
      start = 1'b0;
   endtask

   task automatic check_result(input string tag, input logic [3:0] s, input logic [3:0] c, input logic o);
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_sum"}, out_sum, s);
      check({tag, "_cnt"}, out_carry_cnt, c);
      check({tag, "_ovf"}, out_ovf, o);
      check({tag, "_ready_lo"}, in_ready, 0);
   endtask

   task automatic release_result(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_idle_valid"}, out_valid, 0);
      check({tag, "_idle_busy"}, busy, 0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ready"}, in_ready, 0);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_sum"}, out_sum, 0);
      check({tag, "_cnt"}, out_carry_cnt, 0);
      check({tag, "_ovf"}, out_ovf, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #3;
      check_zero("reset");
      step(); step();
      rst_n = 1'b1;
      step();
      check_zero("post_reset");

      // 7 + 5 = 12, back-to-back operands: valid in cycle 3 after start
      start_burst(4'd2);
      check("t1_ready_acc", in_ready, 1);
      check("t1_busy_acc", busy, 1);
      check("t1_valid_acc", out_valid, 0);
      in_valid = 1'b1; in_data = 4'd7;
      step();
      check("t1_valid_mid", out_valid, 0);
      in_data = 4'd5;
      step();
      in_valid = 1'b0;
      check_result("t1", 4'd12, 4'd0, 1'b0);
      release_result("t1");
      check("t1_sum_kept", out_sum, 12);

      // 15 + 1 wraps to 0 with one carry
      start_burst(4'd2);
      feed(4'hF, 0, "t2a");
      check("t2_valid_mid", out_valid, 0);
      feed(4'h1, 0, "t2b");
      check_result("t2", 4'd0, 4'd1, 1'b1);
      release_result("t2");
      check("t2_ovf_kept", out_ovf, 1);

      // 3 + 5 + 6 = 14 with two-cycle gaps
      start_burst(4'd3);
      check("t3_cnt_cleared", out_carry_cnt, 0);
      feed(4'd3, 2, "t3a");
      feed(4'd5, 2, "t3b");
      check("t3_valid_mid", out_valid, 0);
      feed(4'd6, 2, "t3c");
      check_result("t3", 4'd14, 4'd0, 1'b0);
      release_result("t3");

      // len 0: straight to HOLD with cleared result
      start_burst(4'd0);
      check_result("t4", 4'd0, 4'd0, 1'b0);
      check("t4_busy", busy, 1);
      release_result("t4");

      // backpressure in HOLD with start pulses that must be ignored
      start_burst(4'd1);
      feed(4'd9, 0, "t5");
      for (int k = 0; k < 5; k++) begin
         start = (k % 2 == 0);
         len   = 4'd3;
         step();
         check_result("t5_hold", 4'd9, 4'd0, 1'b0);
      end
      start = 1'b1; out_ready = 1'b1;
      step();
      start = 1'b0; out_ready = 1'b0;
      check("t5_idle_valid", out_valid, 0);
      check("t5_idle_busy", busy, 0);
      step();
      check("t5_start_ignored", busy, 0);
      check("t5_sum_kept", out_sum, 9);

      // 15 x 4'hF: sum 1, 14 carries
      start_burst(4'd15);
      for (int k = 0; k < 15; k++) feed(4'hF, 0, "t6");
      check_result("t6", 4'd1, 4'd14, 1'b1);
      release_result("t6");

      // same burst aborted by reset after 7 operands
      start_burst(4'd15);
      for (int k = 0; k < 7; k++) feed(4'hF, 0, "t7");
      check("t7_partial_sum", out_sum, 9);
      check("t7_partial_cnt", out_carry_cnt, 6);
      rst_n = 1'b0;
      #1;
      check_zero("t7_abort");
      step();
      rst_n = 1'b1;
      step();
      check_zero("t7_after");

      start_burst(4'd2);
      feed(4'hF, 0, "t8a");
      feed(4'h1, 0, "t8b");
      check_result("t8", 4'd0, 4'd1, 1'b1);
      release_result("t8");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/acc_adder_stage.md
Name: acc_adder_stage

Overview:
- Registered accumulation stage directly downstream of the combinational N-bit ripple adder.
- Accepts a burst of LEN operands over a valid/ready input handshake.
- Each accepted operand is added into an N-bit accumulator through a full-adder carry chain.
- Presents the final sum, carry-out count and overflow flag on a valid/ready output handshake; this is the first clocked wrapper around the team's adder datapath.

Parameters:
- N, 4, operand and accumulator width in bits.
- CNT_W, 4, width of the length field and of the carry-out counter.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a burst; sampled only in IDLE.
- len  input  CNT_W  number of operands in the burst; sampled with start.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  stage accepts an operand this cycle.
- in_data  input  N  operand.
- out_valid  output  1  result outputs are valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  N  accumulated sum, modulo 2^N.
- out_carry_cnt  output  CNT_W  number of carry-outs from bit N-1 during the burst; saturates at 2^CNT_W-1.
- out_ovf  output  1  high when out_carry_cnt is non-zero.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous)
  - State goes to IDLE; accumulator, remaining counter and carry counter clear to 0.
  - All outputs go to 0: in_ready, out_valid, out_sum, out_carry_cnt, out_ovf, busy.
  - Reset asserted mid-burst aborts the burst. No result is produced, and no partial state survives deassertion.
- States
  - IDLE: in_ready=0, out_valid=0, busy=0.
  - ACC: in_ready=1, out_valid=0, busy=1.
  - HOLD: in_ready=0, out_valid=1, busy=1.
- IDLE transitions (on start=1)
  - Clear accumulator and carry counter.
  - If len!=0: load remaining=len and go to ACC next cycle.
  - If len==0: go to HOLD with sum 0, carry count 0.
  - start=0: stay in IDLE.
- ACC transitions
  - Handshake occurs when in_valid && in_ready.
  - On each handshake, in the same edge: acc <= (acc + in_data) mod 2^N; remaining decrements by 1.
  - If bit N of the (N+1)-bit sum is 1, the carry counter increments. It saturates at all-ones and does not wrap.
  - Handshake with remaining==1: go to HOLD next cycle.
  - in_valid low: hold all state. Gaps of any length are allowed.
- HOLD transitions
  - out_sum, out_carry_cnt and out_ovf are driven from registers and remain stable while out_valid=1 and out_ready=0.
  - out_ready=1: go to IDLE next cycle and drop out_valid. The result registers keep their last value until the next start.
- Latency
  - First operand is accepted no earlier than 1 cycle after the start edge.
  - out_valid rises 1 cycle after the last operand handshake.
  - Minimum burst of L operands with continuous in_valid: start to out_valid = L+1 cycles.
- start asserted outside IDLE (ACC or HOLD) is ignored, with no effect on state or counters.
- Arithmetic
  - Unsigned throughout; the adder is N bits wide with carry-in 0.
  - out_ovf is combinational from the registered carry count. It is 0 in IDLE after reset and retains its last value otherwise.
- Simultaneous events
  - start in the same cycle as the HOLD-to-IDLE out_ready handshake is ignored. The state is not yet IDLE, so start must be reissued.

Test Plan:
- Reset, start=1, len=2, operands 4'b0111 then 4'b0101 with in_valid continuous -> out_valid at cycle 3 after start; out_sum=4'b1100 (12), out_carry_cnt=0, out_ovf=0.
- len=2, operands 4'b1111 then 4'b0001 -> out_sum=4'b0000, out_carry_cnt=1, out_ovf=1.
- len=3, operands 3, 5, 6 with in_valid low for 2 cycles between each -> in_ready stays 1 throughout ACC; out_sum=14, carry 0; out_valid 1 cycle after the third handshake.
- len=0 with start=1 -> HOLD next cycle with out_sum=0, out_ovf=0, in_ready never 1.
- Burst completes, out_ready held low 5 cycles -> out_valid and outputs stable for 5 cycles; start pulses during HOLD are ignored; out_ready=1 -> IDLE next cycle.
- len=15, all operands 4'b1111 -> out_sum=4'b0001, out_carry_cnt=14. Repeat, but pull rst_n low after the 7th operand -> all outputs 0 immediately; a fresh burst afterwards gives correct results.
